iologic_gearbox: RTL and testbench

- Parametrised, synthesisable behavioural model of an IOLOGIC gearing core, generalising the single-site IOLOGIC_CORE configuration to multi-channel SDR gearing.
- One instance is either an RX deserialiser or a TX serialiser, selected by MODE.
- Runs in the serial-rate clock domain and exposes a parallel word interface with valid/ready handshake.
- RX adds word-alignment bitslip; TX adds underrun detection with an idle pattern.

---
 rtl/iologic_gearbox.sv | 66 ++++++
 tb/tb_iologic_gearbox.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/iologic_gearbox.sv
// iologic_gearbox: multi-lane SDR gearbox, either an RX deserialiser with bitslip or a TX serialiser with underrun idling
module iologic_gearbox #(
  parameter int   CHANNELS = 1,
  parameter int   GEAR     = 4,
  parameter int   MODE     = 0,
  parameter logic IDLE     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      ser_in,
  input  logic                     bitslip,
  output logic [CHANNELS*GEAR-1:0] par_out,
  output logic                     par_out_valid,
  input  logic [CHANNELS*GEAR-1:0] par_in,
  input  logic                     par_in_valid,
  output logic                     par_in_ready,
  output logic [CHANNELS-1:0]      ser_out,
  output logic                     underrun
);
  localparam int CW = $clog2(GEAR);
  localparam int LW = $clog2(GEAR + 1);
  localparam int W = CHANNELS * GEAR;
  localparam bit TX = MODE != 0;
  localparam logic [CW-1:0] LAST = CW'(GEAR - 1);
  if (GEAR != 2 && GEAR != 4 && GEAR != 8) begin : g_bad_gear
    $error("iologic_gearbox: GEAR must be 2, 4 or 8");
  end
  logic [CW-1:0] cnt;
  logic [LW-1:0] lock;
  logic [W-1:0] sr, sr_next;
  logic last, slip, load, bs_q, idle;
  assign last = cnt == LAST;
  assign slip = !TX && bitslip && !bs_q && lock == '0;
  assign load = TX && last && par_in_valid;
  assign par_in_ready = TX && last && !rst;
  // RX shifts the lane bit in at the LSB; TX shifts zeros in behind the outgoing MSB
  always_comb begin
    sr_next = '0;
    ser_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sr_next[c*GEAR +: GEAR] = {sr[c*GEAR +: GEAR-1], TX ? 1'b0 : ser_in[c]};
      ser_out[c] = idle ? IDLE : sr[c*GEAR+GEAR-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      lock <= '0;
      sr <= '0;
      bs_q <= 1'b0;
      idle <= 1'b1;
      underrun <= 1'b0;
      par_out <= '0;
      par_out_valid <= 1'b0;
    end else begin
      cnt <= slip ? cnt : last ? '0 : cnt + CW'(1);
      lock <= slip ? LW'(GEAR) : lock != '0 ? lock - LW'(1) : lock;
      sr <= load ? par_in : sr_next;
      bs_q <= bitslip;
      if (TX && last) idle <= !par_in_valid;
      underrun <= TX && last && !par_in_valid;
      par_out_valid <= !TX && last && !slip;
      if (!TX && last && !slip) par_out <= sr_next;
    end
  end
endmodule

// File: tb/tb_iologic_gearbox.sv
// tb_iologic_gearbox: directed checks of RX capture/bitslip, TX serialise/underrun and reset behaviour
module tb_iologic_gearbox;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] ser_in = '0;
  logic bitslip = 1'b0;
  logic [7:0] par_in = '0;
  logic par_in_valid = 1'b0;
  logic [7:0] rx_par_out, tx0_par_out, tx1_par_out;
  logic rx_valid, tx0_valid, tx1_valid;
  logic rx_ready, tx0_ready, tx1_ready;
  logic [1:0] rx_ser_out, tx0_ser_out, tx1_ser_out;
  logic rx_underrun, tx0_underrun, tx1_underrun;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iologic_gearbox #(.CHANNELS(2), .GEAR(4), .MODE(0), .IDLE(1'b0)) u_rx (
    .clk(clk), .rst(rst), .ser_in(ser_in), .bitslip(bitslip), .par_out(rx_par_out),
    .par_out_valid(rx_valid), .par_in(par_in), .par_in_valid(par_in_valid),
    .par_in_ready(rx_ready), .ser_out(rx_ser_out), .underrun(rx_underrun));
  iologic_gearbox #(.CHANNELS(2), .GEAR(4), .MODE(1), .IDLE(1'b0)) u_tx0 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .bitslip(bitslip), .par_out(tx0_par_out),
    .par_out_valid(tx0_valid), .par_in(par_in), .par_in_valid(par_in_valid),
    .par_in_ready(tx0_ready), .ser_out(tx0_ser_out), .underrun(tx0_underrun));
  iologic_gearbox #(.CHANNELS(2), .GEAR(4), .MODE(1), .IDLE(1'b1)) u_tx1 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .bitslip(bitslip), .par_out(tx1_par_out),
    .par_out_valid(tx1_valid), .par_in(par_in), .par_in_valid(par_in_valid),
    .par_in_ready(tx1_ready), .ser_out(tx1_ser_out), .underrun(tx1_underrun));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ser_in = '0; bitslip = 1'b0; par_in = '0; par_in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ser_in = 2'b11; bitslip = 1'b0; par_in = 8'hFF; par_in_valid = 1'b1;
    repeat (3) step();
    checks++; if (rx_par_out !== 8'h00) begin errors++; $display("FAIL reset_par_out got %h exp 00", rx_par_out); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (rx_ser_out !== 2'b00) begin errors++; $display("FAIL reset_rx_ser_out got %b exp 00", rx_ser_out); end
    checks++; if (tx0_ser_out !== 2'b00) begin errors++; $display("FAIL reset_tx0_ser_out got %b exp 00", tx0_ser_out); end
    checks++; if (tx1_ser_out !== 2'b11) begin errors++; $display("FAIL reset_tx1_ser_out got %b exp 11", tx1_ser_out); end
    checks++; if (tx0_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", tx0_underrun); end
    checks++; if (tx0_ready !== 1'b0 || rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", tx0_ready, rx_ready); end
    checks++; if (tx0_par_out !== 8'h00 || tx0_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_par_out got %h/%b exp 00/0", tx0_par_out, tx0_valid); end
    rst = 1'b0; par_in_valid = 1'b0;
    repeat (3) step();
    checks++; if (tx0_ready !== 1'b1) begin errors++; $display("FAIL slot_ready got %b exp 1", tx0_ready); end
    rst = 1'b1;
    #1;
    checks++; if (tx0_ready !== 1'b0) begin errors++; $display("FAIL ready_in_reset got %b exp 0", tx0_ready); end
    step();
  endtask

  task automatic test_rx_capture();
    logic [3:0] l0, l1;
    l0 = 4'b1011; l1 = 4'b0110;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ser_in = {l1[3-k], l0[3-k]};
      step();
      checks++; if (rx_valid !== (k == 3)) begin errors++; $display("FAIL capture_valid cycle %0d got %b exp %b", k + 1, rx_valid, k == 3); end
    end
    checks++; if (rx_par_out !== 8'h6B) begin errors++; $display("FAIL capture_word got %h exp 6b", rx_par_out); end
    ser_in = 2'b00;
    step();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL capture_strobe_len got %b exp 0", rx_valid); end
    checks++; if (rx_par_out !== 8'h6B) begin errors++; $display("FAIL capture_hold got %h exp 6b", rx_par_out); end
  endtask

  task automatic test_rx_bitslip();
    logic exp_v;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      ser_in = (k % 4 == 0) ? 2'b01 : 2'b00;
      bitslip = (k == 13 || k == 15);
      step();
      exp_v = (k == 3 || k == 7 || k == 11 || k == 16 || k == 20 || k == 24);
      checks++; if (rx_valid !== exp_v) begin errors++; $display("FAIL bitslip_valid edge %0d got %b exp %b", k, rx_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (rx_par_out[3:0] !== (k < 12 ? 4'h8 : 4'h1)) begin
          errors++; $display("FAIL bitslip_word edge %0d got %h exp %h", k, rx_par_out[3:0], k < 12 ? 4'h8 : 4'h1);
        end
      end
    end
    bitslip = 1'b0;
  endtask

  task automatic test_tx_serialise();
    logic [1:0] exp0, exp1;
    do_reset();
    par_in = 8'hA5; par_in_valid = 1'b1;
    checks++; if (tx0_ser_out !== 2'b00 || tx1_ser_out !== 2'b11) begin errors++; $display("FAIL tx_idle_start got %b/%b exp 00/11", tx0_ser_out, tx1_ser_out); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (tx0_ready !== (k % 4 == 3)) begin errors++; $display("FAIL tx_ready cycle %0d got %b exp %b", k, tx0_ready, k % 4 == 3); end
      step();
      exp0 = (k < 3) ? 2'b00 : (k % 2 == 1) ? 2'b10 : 2'b01;
      exp1 = (k < 3) ? 2'b11 : exp0;
      checks++; if (tx0_ser_out !== exp0) begin errors++; $display("FAIL tx_ser0 cycle %0d got %b exp %b", k + 1, tx0_ser_out, exp0); end
      checks++; if (tx1_ser_out !== exp1) begin errors++; $display("FAIL tx_ser1 cycle %0d got %b exp %b", k + 1, tx1_ser_out, exp1); end
      checks++; if (tx0_underrun !== 1'b0) begin errors++; $display("FAIL tx_no_underrun cycle %0d got %b exp 0", k + 1, tx0_underrun); end
    end
    par_in_valid = 1'b0;
  endtask

  task automatic test_tx_underrun();
    logic [1:0] tbl [16] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01,
                             2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
    do_reset();
    for (int k = 0; k < 15; k++) begin
      par_in_valid = (k == 3 || k == 9 || k == 11);
      par_in = (k == 3) ? 8'hA5 : (k == 9) ? 8'h00 : (k == 11) ? 8'h3C : 8'hFF;
      step();
      checks++; if (tx1_ser_out !== tbl[k+1]) begin errors++; $display("FAIL underrun_ser cycle %0d got %b exp %b", k + 1, tx1_ser_out, tbl[k+1]); end
      checks++; if (tx1_underrun !== (k == 7)) begin errors++; $display("FAIL underrun_pulse cycle %0d got %b exp %b", k + 1, tx1_underrun, k == 7); end
    end
    par_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ser_in = 2'b11;
    repeat (6) step();
    checks++; if (rx_par_out !== 8'hFF) begin errors++; $display("FAIL mid_pre_word got %h exp ff", rx_par_out); end
    rst = 1'b1;
    step();
    checks++; if (rx_par_out !== 8'h00 || rx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got %h/%b exp 00/0", rx_par_out, rx_valid); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ser_in = (k == 0) ? 2'b11 : 2'b00;
      step();
      checks++; if (rx_valid !== (k == 3)) begin errors++; $display("FAIL mid_valid cycle %0d got %b exp %b", k + 1, rx_valid, k == 3); end
    end
    checks++; if (rx_par_out !== 8'h88) begin errors++; $display("FAIL mid_word got %h exp 88", rx_par_out); end
  endtask

  initial begin
    test_reset();
    test_rx_capture();
    test_rx_bitslip();
    test_tx_serialise();
    test_tx_underrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
